// File: rtl/pkt_buffer_writer.sv
// pkt_buffer_writer: AXI4-Stream ingress stage. Each accepted beat is written
// into a circular packet buffer through BRAM port A; every completed packet
// yields one descriptor (start address, beat count, last tkeep, tuser, rank)
// for the PIFO. Packets longer than MAX_PKT_BEATS are discarded and counted.
//
// Handshakes: a beat transfers on a rising clk edge where s_axis_tvalid and
// s_axis_tready are both high, and a descriptor transfers where desc_valid and
// desc_ready are both high. s_axis_tready never looks at s_axis_tvalid. Once
// desc_valid is raised, the descriptor fields stay put until desc_ready is seen.
module pkt_buffer_writer #(
    parameter int DATA_WIDTH      = 256,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int SUME_META_WIDTH = 128,
    parameter int ADDR_WIDTH      = 11,
    parameter int MAX_PKT_BEATS   = 64,
    parameter int LEN_WIDTH       = 8,
    parameter int RANK_LSB        = 64,
    parameter int RANK_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic [SUME_META_WIDTH-1:0] s_axis_tuser,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       bram_wea,
    output logic [ADDR_WIDTH-1:0]      bram_addra,
    output logic [DATA_WIDTH-1:0]      bram_dina,
    input  logic [ADDR_WIDTH-1:0]      rd_free_ptr,
    output logic                       desc_valid,
    input  logic                       desc_ready,
    output logic [ADDR_WIDTH-1:0]      desc_addr,
    output logic [LEN_WIDTH-1:0]       desc_len,
    output logic [KEEP_WIDTH-1:0]      desc_last_keep,
    output logic [SUME_META_WIDTH-1:0] desc_tuser,
    output logic [RANK_WIDTH-1:0]      desc_rank,
    output logic [31:0]                drop_count,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH:0] MAX_CNT = (LEN_WIDTH + 1)'(MAX_PKT_BEATS);

    state_t                     state, state_next;
    logic [ADDR_WIDTH-1:0]      wr_ptr, pkt_start, occ;
    logic [LEN_WIDTH:0]         beat_cnt, cnt_next;
    logic [SUME_META_WIDTH-1:0] tuser_q;
    logic                       full, accept, run;
    logic                       do_write, do_start, do_emit, do_rewind, do_drop;
    logic [ADDR_WIDTH-1:0]      emit_addr;
    logic [LEN_WIDTH-1:0]       emit_len;
    logic [SUME_META_WIDTH-1:0] emit_tuser;
    logic                       desc_free;

    // Staging slot between the tlast beat and the visible descriptor.
    logic                       pend_valid;
    logic [ADDR_WIDTH-1:0]      pend_addr;
    logic [LEN_WIDTH-1:0]       pend_len;
    logic [KEEP_WIDTH-1:0]      pend_keep;
    logic [SUME_META_WIDTH-1:0] pend_tuser;

    // Occupancy wraps naturally in ADDR_WIDTH bits; one slot is kept empty.
    assign occ       = wr_ptr - rd_free_ptr;
    assign full      = (occ == {ADDR_WIDTH{1'b1}});
    assign desc_free = !desc_valid || desc_ready;
    // run holds tready low until the first clock after reset release.
    assign s_axis_tready = run && ((state == DROP) || (!full && desc_free));
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign cnt_next  = beat_cnt + (LEN_WIDTH + 1)'(1);
    assign desc_rank = desc_tuser[RANK_LSB +: RANK_WIDTH];
    assign state_dbg = state;

    // A single-beat packet is emitted straight from IDLE using live inputs.
    assign emit_addr  = (state == IDLE) ? wr_ptr : pkt_start;
    assign emit_len   = (state == IDLE) ? LEN_WIDTH'(1) : cnt_next[LEN_WIDTH-1:0];
    assign emit_tuser = (state == IDLE) ? s_axis_tuser : tuser_q;

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and per-beat actions.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_start   = 1'b0;
        do_emit    = 1'b0;
        do_rewind  = 1'b0;
        do_drop    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    do_write = 1'b1;
                    do_start = 1'b1;
                    if (s_axis_tlast) do_emit = 1'b1;
                    else              state_next = WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    if (cnt_next > MAX_CNT) begin
                        // Oversized: discard what was written by rewinding.
                        do_rewind = 1'b1;
                        if (s_axis_tlast) begin
                            do_drop    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = DROP;
                        end
                    end else begin
                        do_write = 1'b1;
                        if (s_axis_tlast) begin
                            do_emit    = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (accept && s_axis_tlast) begin
                    do_drop    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write pointer, packet bookkeeping and the registered BRAM write port.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            run        <= 1'b0;
            wr_ptr     <= '0;
            pkt_start  <= '0;
            beat_cnt   <= '0;
            tuser_q    <= '0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            drop_count <= '0;
        end else begin
            run      <= 1'b1;
            bram_wea <= do_write;
            if (do_write) begin
                bram_addra <= wr_ptr;
                bram_dina  <= s_axis_tdata;
            end
            if (do_rewind)     wr_ptr <= pkt_start;
            else if (do_write) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (do_start) begin
                pkt_start <= wr_ptr;
                beat_cnt  <= (LEN_WIDTH + 1)'(1);
                tuser_q   <= s_axis_tuser;
            end else if (do_write) begin
                beat_cnt <= cnt_next;
            end
            if (do_drop && (drop_count != 32'hFFFF_FFFF))
                drop_count <= drop_count + 32'd1;
        end
    end

    // Two-stage descriptor path: staging slot, then the held output register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pend_valid     <= 1'b0;
            pend_addr      <= '0;
            pend_len       <= '0;
            pend_keep      <= '0;
            pend_tuser     <= '0;
            desc_valid     <= 1'b0;
            desc_addr      <= '0;
            desc_len       <= '0;
            desc_last_keep <= '0;
            desc_tuser     <= '0;
        end else begin
            if (desc_free) begin
                desc_valid <= pend_valid;
                if (pend_valid) begin
                    desc_addr      <= pend_addr;
                    desc_len       <= pend_len;
                    desc_last_keep <= pend_keep;
                    desc_tuser     <= pend_tuser;
                end
            end
            // An emit always coincides with desc_free, so the slot is drained.
            if (do_emit) begin
                pend_valid <= 1'b1;
                pend_addr  <= emit_addr;
                pend_len   <= emit_len;
                pend_keep  <= s_axis_tkeep;
                pend_tuser <= emit_tuser;
            end else if (desc_free) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
